// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : Multicycle fetch/branch sequencer that owns the program counter.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'd1
) (
  input  logic              Clk,
  input  logic              Reset,
  output logic              Imem_Req,
  output logic [ADDR_W-1:0] Imem_Addr,
  input  logic              Imem_Ack,
  input  logic [31:0]       Imem_Data,
  output logic [31:0]       Inst,
  output logic              Inst_Valid,
  input  logic              Inst_Ready,
  input  logic              Br_Valid,
  input  logic              Br,
  input  logic              Zero,
  input  logic [15:0]       Imm,
  output logic [ADDR_W-1:0] PC,
  output logic [31:0]       Retired
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    RESOLVE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;
  logic              inst_valid_q, inst_valid_d;
  logic              imem_req_q, imem_req_d;
  logic [31:0]       retired_q, retired_d;
  logic [ADDR_W-1:0] br_offset;

  // Offset is added only for a taken beq; otherwise the step is a plain +1.
  assign br_offset = (Br && Zero) ? {{(ADDR_W-16){Imm[15]}}, Imm} : '0;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    retired_d    = retired_q;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (Imem_Ack) begin
          inst_d       = Imem_Data;
          inst_valid_d = 1'b1;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (Inst_Ready) begin
          inst_valid_d = 1'b0;
          state_d      = RESOLVE;
        end
      end
      RESOLVE: begin
        if (Br_Valid) begin
          pc_d      = pc_q + ADDR_W'(1) + br_offset;
          retired_d = retired_q + 32'd1;
          state_d   = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
    // Request is registered off the next state so it tracks FETCH exactly.
    imem_req_d = (state_d == FETCH);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      inst_q       <= 32'd0;
      inst_valid_q <= 1'b0;
      imem_req_q   <= 1'b0;
      retired_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      imem_req_q   <= imem_req_d;
      retired_q    <= retired_d;
    end
  end

  assign Imem_Req   = imem_req_q;
  assign Imem_Addr  = pc_q;
  assign PC         = pc_q;
  assign Inst       = inst_q;
  assign Inst_Valid = inst_valid_q;
  assign Retired    = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Transaction-level randomized bench for pc_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Imem_Req;
  logic [31:0] Imem_Addr;
  logic        Imem_Ack = 1'b0;
  logic [31:0] Imem_Data = 32'd0;
  logic [31:0] Inst;
  logic        Inst_Valid;
  logic        Inst_Ready = 1'b0;
  logic        Br_Valid = 1'b0;
  logic        Br = 1'b0;
  logic        Zero = 1'b0;
  logic [15:0] Imm = 16'd0;
  logic [31:0] PC;
  logic [31:0] Retired;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_pc  = 32'd1;
  logic [31:0] m_ret = 32'd0;

  pc_sequencer #(.ADDR_W(32), .RESET_PC(32'd1)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Imem_Req   (Imem_Req),
    .Imem_Addr  (Imem_Addr),
    .Imem_Ack   (Imem_Ack),
    .Imem_Data  (Imem_Data),
    .Inst       (Inst),
    .Inst_Valid (Inst_Valid),
    .Inst_Ready (Inst_Ready),
    .Br_Valid   (Br_Valid),
    .Br         (Br),
    .Zero       (Zero),
    .Imm        (Imm),
    .PC         (PC),
    .Retired    (Retired)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic coin();
    return ($urandom_range(0, 1) == 1);
  endfunction

  task automatic idle_inputs();
    Imem_Ack   = 1'b0;
    Inst_Ready = 1'b0;
    Br_Valid   = 1'b0;
  endtask

  // One complete instruction, entered in the first FETCH cycle. Handshakes
  // land after ad/rd/bd wait cycles; strays are driven where they must be ignored.
  task automatic do_instr(input int ad, input int rd, input int bd,
                          input logic br, input logic zero, input logic [15:0] imm,
                          input logic stray);
    logic [31:0] data;
    logic [31:0] off;
    data = $urandom;
    for (int i = 0; i <= ad; i++) begin
      check("fetch_req", {31'd0, Imem_Req}, 32'd1);
      check("fetch_addr", Imem_Addr, m_pc);
      check("fetch_valid", {31'd0, Inst_Valid}, 32'd0);
      check("fetch_retired", Retired, m_ret);
      Imem_Ack   = (i == ad);
      Imem_Data  = (i == ad) ? data : $urandom;
      Inst_Ready = stray || coin();
      Br_Valid   = stray || coin();
      Br = coin(); Zero = coin(); Imm = 16'($urandom);
      tick();
    end
    for (int j = 0; j <= rd; j++) begin
      check("hold_req", {31'd0, Imem_Req}, 32'd0);
      check("hold_valid", {31'd0, Inst_Valid}, 32'd1);
      check("hold_inst", Inst, data);
      check("hold_pc", PC, m_pc);
      Inst_Ready = (j == rd);
      Imem_Ack   = stray || coin();
      Imem_Data  = $urandom;
      Br_Valid   = stray || coin();
      Br = coin(); Zero = coin(); Imm = 16'($urandom);
      tick();
    end
    for (int k = 0; k <= bd; k++) begin
      check("res_req", {31'd0, Imem_Req}, 32'd0);
      check("res_valid", {31'd0, Inst_Valid}, 32'd0);
      check("res_inst", Inst, data);
      check("res_pc", PC, m_pc);
      check("res_retired", Retired, m_ret);
      Br_Valid   = (k == bd);
      Br         = (k == bd) ? br   : coin();
      Zero       = (k == bd) ? zero : coin();
      Imm        = (k == bd) ? imm  : 16'($urandom);
      Imem_Ack   = stray || coin();
      Imem_Data  = $urandom;
      Inst_Ready = stray || coin();
      tick();
    end
    idle_inputs();
    off   = (br && zero) ? 32'($signed(imm)) : 32'd0;
    m_pc  = m_pc + 32'd1 + off;
    m_ret = m_ret + 32'd1;
  endtask

  // Reset with every handshake asserted; expects the BOOT values and a
  // quiet BOOT cycle before FETCH returns.
  task automatic do_reset(input string tag);
    Reset      = 1'b1;
    Imem_Ack   = 1'b1;
    Inst_Ready = 1'b1;
    Br_Valid   = 1'b1;
    Br = 1'b1; Zero = 1'b1;
    Imem_Data  = $urandom;
    tick();
    check({tag, "_pc"}, PC, 32'd1);
    check({tag, "_inst"}, Inst, 32'd0);
    check({tag, "_valid"}, {31'd0, Inst_Valid}, 32'd0);
    check({tag, "_req"}, {31'd0, Imem_Req}, 32'd0);
    check({tag, "_retired"}, Retired, 32'd0);
    Reset = 1'b0;
    idle_inputs();
    m_pc  = 32'd1;
    m_ret = 32'd0;
    tick();
  endtask

  initial begin
    tick();
    tick();
    check("rst_pc", PC, 32'd1);
    check("rst_addr", Imem_Addr, 32'd1);
    check("rst_req", {31'd0, Imem_Req}, 32'd0);
    check("rst_valid", {31'd0, Inst_Valid}, 32'd0);
    check("rst_inst", Inst, 32'd0);
    check("rst_retired", Retired, 32'd0);
    Reset = 1'b0;
    tick();

    // Back-to-back non-branches at minimum latency: addresses 1,2,3,4.
    for (int n = 0; n < 4; n++) do_instr(0, 0, 0, 1'b0, 1'b0, 16'd0, 1'b0);
    check("retired_after4", Retired, 32'd4);
    check("pc_is_5", PC, 32'd5);

    do_instr(0, 0, 0, 1'b1, 1'b1, 16'd10, 1'b1);
    check("taken_fwd", Imem_Addr, 32'd16);
    do_instr(0, 0, 0, 1'b1, 1'b1, 16'hFFF4, 1'b0);
    check("back_to_5", Imem_Addr, 32'd5);
    do_instr(0, 0, 0, 1'b1, 1'b1, 16'hFFFC, 1'b1);
    check("taken_back", Imem_Addr, 32'd2);
    do_instr(0, 0, 0, 1'b1, 1'b1, 16'd2, 1'b0);
    do_instr(0, 0, 0, 1'b1, 1'b0, 16'd10, 1'b1);
    check("br_no_zero", Imem_Addr, 32'd6);
    do_instr(1, 1, 1, 1'b0, 1'b1, 16'd10, 1'b1);
    check("zero_no_br", Imem_Addr, 32'd7);

    do_instr(0, 0, 0, 1'b1, 1'b1, 16'hFFF7, 1'b0);
    check("pc_all_ones", PC, 32'hFFFF_FFFF);
    do_instr(0, 0, 2, 1'b0, 1'b0, 16'd0, 1'b1);
    check("pc_wrap", Imem_Addr, 32'd0);

    do_instr(4, 2, 0, 1'b0, 1'b0, 16'd0, 1'b1);

    for (int n = 0; n < 40; n++)
      do_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               coin(), coin(), 16'($urandom), coin());

    do_reset("rst_fetch");
    do_instr(0, 0, 0, 1'b0, 1'b0, 16'd0, 1'b0);

    Imem_Ack  = 1'b1;
    Imem_Data = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    check("pre_rst_hold_valid", {31'd0, Inst_Valid}, 32'd1);
    do_reset("rst_hold");
    do_instr(1, 0, 1, 1'b1, 1'b1, 16'd3, 1'b0);
    check("post_rst_branch", Imem_Addr, 32'd5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
